pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register, the successor to the fixed 64-bit IF/ID stage register. It carries an arbitrary-width payload between any two pipeline stages with a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered, so it never depends combinationally on `out_ready`. It keeps the existing freeze (stall) and flush semantics and adds backpressure and occupancy reporting.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_reg_if.sv | 21 ++
 rtl/pipe_slot.sv | 47 ++++
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: state encoding, occupancy type, flush default.
package pipe_pkg;

  localparam int PIPE_OCC_W = 2;
  typedef logic [PIPE_OCC_W-1:0] pipe_occ_t;

  // State encoding equals the number of held entries.
  localparam pipe_occ_t PS_EMPTY = 2'd0;
  localparam pipe_occ_t PS_HALF  = 2'd1;
  localparam pipe_occ_t PS_FULL  = 2'd2;

  localparam int PIPE_MAX_W = 4096;

  function automatic logic [PIPE_MAX_W-1:0] pipe_flush_default();
    return '0;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream valid/ready channels of one pipeline stage.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus data register; clear > load > drop > hold.
// Data is kept on drop so a stale value stays visible while the slot is invalid.
module pipe_slot #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] dat_d, dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear_i) begin
      vld_d = 1'b0;
      dat_d = FLUSH_VALUE;
    end else if (load_i) begin
      vld_d = 1'b1;
      dat_d = dat_i;
    end else if (drop_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= FLUSH_VALUE;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage with a two-entry skid buffer; one cycle latency, one word/cycle.
// in_ready depends only on registered skid state, freeze and reset, never on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = WIDTH'(pipe_flush_default())
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   freeze,
  pipe_stage_reg_if.slave        bus,
  output pipe_occ_t              occupancy
);

  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_dat, skid_dat;
  logic             push, pop;
  logic             main_load, main_drop, skid_load, skid_drop;
  logic [WIDTH-1:0] main_src;
  logic             main_nv, skid_nv;
  pipe_occ_t        cur_st;
  pipe_occ_t        occ_d, occ_q;

  assign bus.in_ready  = rst & ~skid_v & ~freeze;
  assign bus.out_valid = main_v & ~freeze;
  assign bus.out_data  = main_dat;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign cur_st = skid_v ? PS_FULL : (main_v ? PS_HALF : PS_EMPTY);

  // Freeze needs no explicit term: it already forces push and pop low.
  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    main_src  = bus.in_data;
    case (cur_st)
      PS_EMPTY: main_load = push;
      PS_HALF: begin
        if (push) begin
          if (pop) main_load = 1'b1;
          else     skid_load = 1'b1;
        end else if (pop) begin
          main_drop = 1'b1;
        end
      end
      PS_FULL: begin
        if (pop) begin
          main_load = 1'b1;
          main_src  = skid_dat;
          skid_drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign main_nv = ~flush & (main_load | (main_v & ~main_drop));
  assign skid_nv = ~flush & (skid_load | (skid_v & ~skid_drop));
  assign occ_d   = pipe_occ_t'({1'b0, main_nv}) + pipe_occ_t'({1'b0, skid_nv});

  pipe_slot #(.WIDTH(WIDTH), .FLUSH_VALUE(FLUSH_VALUE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .clear_i (flush),
    .dat_i   (main_src),
    .vld_o   (main_v),
    .dat_o   (main_dat)
  );

  pipe_slot #(.WIDTH(WIDTH), .FLUSH_VALUE(FLUSH_VALUE)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drop_i  (skid_drop),
    .clear_i (flush),
    .dat_i   (bus.in_data),
    .vld_o   (skid_v),
    .dat_o   (skid_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= PS_EMPTY;
    else      occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg with a 64-bit payload.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, freeze;
  logic [1:0]  occupancy;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] q[$];

  pipe_stage_reg_if #(.WIDTH(64)) bus ();

  pipe_stage_reg #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    freeze        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst0_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst0_in_ready got %0b want 0", bus.in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst0_occ got %0d want 0", occupancy); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL rst0_out_data got %h want 0", bus.out_data); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %0b want 1", bus.in_ready); end
    step();
    // Fill to FULL, then assert reset asynchronously mid-cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hAAAA;
    step();
    bus.in_data  = 64'hBBBB;
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ got %0d want 2", occupancy); end
    checks++; if (bus.out_data !== 64'hAAAA) begin errors++; $display("FAIL fill_data got %h want aaaa", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b want 0", bus.in_ready); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL mid_rst_out_data got %h want 0", bus.out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL mid_rst_occ got %0d want 0", occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %0b want 0", bus.in_ready); end
    step();
    rst = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL post_rst_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_stream();
    idle();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'(k);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", k, bus.in_ready); end
      step();
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'(k)) begin
        errors++; $display("FAIL stream_out[%0d] got v=%0b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_data, 64'(k));
      end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", k, occupancy); end
    end
    bus.in_valid = 1'b0;
    step();
    #1;
    checks++; if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain got occ=%0d v=%0b want occ=0 v=0", occupancy, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h11;
    step();
    bus.in_data  = 64'h22;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_half_in_ready got %0b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d want 2", occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h11) begin
      errors++; $display("FAIL bp_pop1 got v=%0b d=%h want v=1 d=11", bus.out_valid, bus.out_data);
    end
    step();
    #1;
    checks++; if (bus.out_data !== 64'h22 || occupancy !== 2'd1) begin
      errors++; $display("FAIL bp_pop2 got d=%h occ=%0d want d=22 occ=1", bus.out_data, occupancy);
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", bus.in_ready); end
    step();
    #1;
    checks++; if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got occ=%0d v=%0b want occ=0 v=0", occupancy, bus.out_valid);
    end
  endtask

  task automatic test_freeze();
    idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h11;
    step();
    bus.in_data  = 64'h22;
    step();
    freeze       = 1'b1;
    bus.in_data  = 64'h33;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL frz_hs[%0d] got v=%0b r=%0b want 0 0", c, bus.out_valid, bus.in_ready);
      end
      checks++; if (occupancy !== 2'd2 || bus.out_data !== 64'h11) begin
        errors++; $display("FAIL frz_hold[%0d] got occ=%0d d=%h want occ=2 d=11", c, occupancy, bus.out_data);
      end
      step();
    end
    freeze        = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h11 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL frz_release got v=%0b d=%h r=%0b want 1 11 0", bus.out_valid, bus.out_data, bus.in_ready);
    end
    step();
    #1;
    checks++; if (bus.out_data !== 64'h22 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL frz_second got d=%h r=%0b want 22 1", bus.out_data, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_data !== 64'h33 || occupancy !== 2'd1) begin
      errors++; $display("FAIL frz_third got d=%h occ=%0d want 33 1", bus.out_data, occupancy);
    end
    step();
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL frz_empty got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h55;
    step();
    flush       = 1'b1;
    freeze      = 1'b1;
    bus.in_data = 64'h44;
    step();
    idle();
    #1;
    checks++; if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_state got occ=%0d v=%0b want 0 0", occupancy, bus.out_valid);
    end
    checks++; if (bus.out_data !== 64'h0) begin errors++; $display("FAIL flush_data got %h want 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got v=%0b want 0", c, bus.out_valid); end
    end
    // Flush from FULL must discard the skid entry as well.
    idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h66;
    step();
    bus.in_data  = 64'h77;
    step();
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h88;
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_data !== 64'h88 || occupancy !== 2'd1) begin
      errors++; $display("FAIL flush_full got d=%h occ=%0d want 88 1", bus.out_data, occupancy);
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_full_drain got occ=%0d v=%0b want 0 0", occupancy, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic m_rdy, m_vld, push, pop;
    idle();
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 6);
      bus.in_data   = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 9) < 6);
      freeze        = ($urandom_range(0, 9) == 0);
      flush         = ($urandom_range(0, 31) == 0);
      #1;
      m_rdy = (q.size() < 2) && !freeze;
      m_vld = (q.size() > 0) && !freeze;
      checks++; if (bus.in_ready !== m_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", n, bus.in_ready, m_rdy); end
      checks++; if (bus.out_valid !== m_vld) begin errors++; $display("FAIL rnd_out_valid[%0d] got %0b want %0b", n, bus.out_valid, m_vld); end
      if (m_vld) begin
        checks++; if (bus.out_data !== q[0]) begin errors++; $display("FAIL rnd_out_data[%0d] got %h want %h", n, bus.out_data, q[0]); end
      end
      checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ[%0d] got %0d want %0d", n, occupancy, q.size()); end
      checks++; if (dut.skid_v === 1'b1 && dut.main_v !== 1'b1) begin
        errors++; $display("FAIL rnd_invariant[%0d] got skid=1 main=%0b want main=1", n, dut.main_v);
      end
      push = bus.in_valid && m_rdy;
      pop  = m_vld && bus.out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(bus.in_data);
      end
      step();
      if (errors > 40) break;
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
